// File: rtl/kbd_source_arbiter_if.sv
// Keyboard source arbiter bus: UART/PS/2 byte strobes in, PIA KBD/KBDCR view out.
// master = front-ends plus CPU side; slave = the arbiter.
interface kbd_source_arbiter_if;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       ps2_valid;
  logic [7:0] ps2_data;
  logic [1:0] src_en;
  logic       kbd_rd;
  logic       clr_ovf;
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic [1:0] ovf;

  modport master (
    output uart_valid, uart_data, ps2_valid, ps2_data, src_en, kbd_rd, clr_ovf,
    input  kbd_ready, kbd_data, ovf
  );

  modport slave (
    input  uart_valid, uart_data, ps2_valid, ps2_data, src_en, kbd_rd, clr_ovf,
    output kbd_ready, kbd_data, ovf
  );
endinterface

// File: rtl/kbd_source_arbiter.sv
// Round-robin sharing of the Apple-1 KBD register between UART and PS/2 byte sources.
// Optional: define KBD_UPPERCASE_FOLD_EN to fold a-z to A-Z when bytes are queued.
module kbd_source_arbiter #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic                 clk25,
  input  logic                 rst,
  kbd_source_arbiter_if.slave  bus
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned PW       = AW + 1;
  localparam int unsigned HW       = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, GAP} state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    mem    [2][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic [7:0]    wdata  [2];

  logic [1:0]    push_req;
  logic [1:0]    push_ok;
  logic [1:0]    push_drop;
  logic [1:0]    empty;
  logic [1:0]    full;
  logic [1:0]    req;

  logic [1:0]    pop_c;
  logic          grant_sel_c;
  logic          load_en_c;
  logic          rd_ack_c;
  logic          gap_run_c;

  logic          last_grant;
  logic [7:0]    pop_byte_q;
  logic [7:0]    kbd_data_q;
  logic          kbd_ready_q;
  logic [1:0]    ovf_q;
  logic [HW-1:0] gap_cnt;

  logic          unused_msbs;

  // Queued form of a byte: bit7 forced high, optional case fold.
  function automatic logic [7:0] store_byte(input logic [6:0] c);
`ifdef KBD_UPPERCASE_FOLD_EN
    if (c >= 7'h61 && c <= 7'h7A) begin
      return {1'b1, c & 7'h5F};
    end
`endif
    return {1'b1, c};
  endfunction

  assign unused_msbs = bus.uart_data[7] ^ bus.ps2_data[7];

  always_comb begin
    push_req = {bus.ps2_valid & bus.src_en[1], bus.uart_valid & bus.src_en[0]};
    wdata[0] = store_byte(bus.uart_data[6:0]);
    wdata[1] = store_byte(bus.ps2_data[6:0]);
  end

  // Pointer-based FIFO status; a disabled source never requests a grant.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
    end
    req = ~empty & bus.src_en;
  end

  // A full FIFO still takes a byte when its head leaves in the same cycle.
  always_comb begin
    push_ok   = push_req & (~full | pop_c);
    push_drop = push_req & full & ~pop_c;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!bus.src_en[i]) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
          if (pop_c[i])   rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk25) begin
    for (int i = 0; i < 2; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i][AW-1:0]] <= wdata[i];
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = LOAD;
      LOAD:    state_nxt = HOLD;
      HOLD:    if (bus.kbd_rd) state_nxt = (HOLDOFF_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == HW'(GAP_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tie between two waiting sources goes to the one not served last.
  always_comb begin
    pop_c       = 2'b00;
    grant_sel_c = last_grant;
    load_en_c   = 1'b0;
    rd_ack_c    = 1'b0;
    gap_run_c   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_sel_c = (req == 2'b11) ? ~last_grant : req[1];
          pop_c       = grant_sel_c ? 2'b10 : 2'b01;
        end
      end
      LOAD:    load_en_c = 1'b1;
      HOLD:    rd_ack_c  = bus.kbd_rd;
      GAP:     gap_run_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      last_grant  <= 1'b0;
      pop_byte_q  <= 8'h80;
      kbd_data_q  <= 8'h80;
      kbd_ready_q <= 1'b0;
      ovf_q       <= 2'b00;
      gap_cnt     <= '0;
    end else begin
      if (pop_c != 2'b00) begin
        last_grant <= grant_sel_c;
        pop_byte_q <= mem[grant_sel_c][rd_ptr[grant_sel_c][AW-1:0]];
      end
      if (load_en_c) begin
        kbd_data_q  <= pop_byte_q;
        kbd_ready_q <= 1'b1;
      end
      if (rd_ack_c) kbd_ready_q <= 1'b0;
      gap_cnt <= gap_run_c ? gap_cnt + HW'(1) : '0;
      // A fresh drop wins over a clear request on the same bit.
      ovf_q   <= push_drop | (ovf_q & ~{2{bus.clr_ovf}});
    end
  end

  assign bus.kbd_ready = kbd_ready_q;
  assign bus.kbd_data  = kbd_data_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_kbd_source_arbiter.sv
// Bench for kbd_source_arbiter: per-source timestamped queues feed a scoreboard
// that checks every newly presented key against the arbitration rules.
module tb_kbd_source_arbiter;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HOLDOFF    = 2;

  logic clk25 = 1'b0;
  logic rst;
  always #20 clk25 = ~clk25;

  kbd_source_arbiter_if ifc();

  kbd_source_arbiter #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .HOLDOFF_CYCLES (HOLDOFF)
  ) dut (
    .clk25 (clk25),
    .rst   (rst),
    .bus   (ifc)
  );

  typedef struct {
    logic [7:0] d;
    int         t;
  } ent_t;

  ent_t uq[$];
  ent_t pq[$];
  bit   last_ps2;
  bit   prev_ready;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk25) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] stored(input logic [7:0] d);
    logic [6:0] c;
    c = d[6:0];
`ifdef KBD_UPPERCASE_FOLD_EN
    if (c >= 7'd97 && c <= 7'd122) c = c - 7'd32;
`endif
    return {1'b1, c};
  endfunction

  // Scoreboard: a byte pushed at edge t is grantable at edge g when t < g; presentation follows the grant by one edge.
  always @(negedge clk25) begin : monitor
    ent_t e;
    bit   eu, ep, src;
    int   g;
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (ifc.kbd_ready && !prev_ready) begin
        g  = cyc - 1;
        eu = (uq.size() > 0) && (uq[0].t <= g - 1);
        ep = (pq.size() > 0) && (pq[0].t <= g - 1);
        if (!eu && !ep) begin
          n_checks++;
          n_fail++;
          $display("FAIL present: key %h shown with nothing eligible (cycle %0d)", ifc.kbd_data, cyc);
        end else begin
          src = (eu && ep) ? !last_ps2 : ep;
          if (src) e = pq.pop_front();
          else     e = uq.pop_front();
          last_ps2 = src;
          check("present", ifc.kbd_data, e.d);
        end
      end
      prev_ready = ifc.kbd_ready;
    end
  end

  task automatic next();
    @(negedge clk25);
    #1;
    ifc.uart_valid = 1'b0;
    ifc.ps2_valid  = 1'b0;
    ifc.kbd_rd     = 1'b0;
    ifc.clr_ovf    = 1'b0;
  endtask

  task automatic push(input bit src, input logic [7:0] d, input bit expect_acc);
    ent_t e;
    e.d = stored(d);
    e.t = cyc + 1;
    if (!src) begin
      ifc.uart_valid = 1'b1;
      ifc.uart_data  = d;
      if (expect_acc && ifc.src_en[0]) uq.push_back(e);
    end else begin
      ifc.ps2_valid = 1'b1;
      ifc.ps2_data  = d;
      if (expect_acc && ifc.src_en[1]) pq.push_back(e);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ifc.kbd_ready && n < 40) begin
      next();
      n++;
    end
    if (!ifc.kbd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: kbd_ready still 0 after %0d cycles", name, n);
    end
  endtask

  task automatic read_key();
    ifc.kbd_rd = 1'b1;
    next();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uq.delete();
    pq.delete();
    last_ps2 = 1'b0;
    repeat (3) next();
  endtask

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    int         n;
    rst            = 1'b1;
    ifc.uart_valid = 1'b0;
    ifc.uart_data  = 8'h00;
    ifc.ps2_valid  = 1'b0;
    ifc.ps2_data   = 8'h00;
    ifc.src_en     = 2'b11;
    ifc.kbd_rd     = 1'b0;
    ifc.clr_ovf    = 1'b0;
    last_ps2       = 1'b0;
    repeat (3) next();
    check("rst_ready", 8'(ifc.kbd_ready), 8'h00);
    check("rst_data", ifc.kbd_data, 8'h80);
    check("rst_ovf", 8'(ifc.ovf), 8'h00);
    rst = 1'b0;
    next();

    // Latency: push edge E, pop E+1, kbd_ready at E+2.
    push(0, 8'h0D, 1'b1);
    next();
    check("lat_e0_ready", 8'(ifc.kbd_ready), 8'h00);
    next();
    check("lat_e1_ready", 8'(ifc.kbd_ready), 8'h00);
    next();
    check("lat_e2_ready", 8'(ifc.kbd_ready), 8'h01);
    check("lat_e2_data", ifc.kbd_data, 8'h8D);
    next();
    next();
    check("hold_ready", 8'(ifc.kbd_ready), 8'h01);
    check("hold_data", ifc.kbd_data, 8'h8D);
    read_key();
    check("rd_clear", 8'(ifc.kbd_ready), 8'h00);

    // Reset during GAP with a byte pending.
    push(0, 8'h55, 1'b1);
    next();
    do_reset();
    check("gap_rst_ready", 8'(ifc.kbd_ready), 8'h00);
    check("gap_rst_data", ifc.kbd_data, 8'h80);
    rst = 1'b0;
    repeat (6) next();
    check("gap_rst_dropped", 8'(ifc.kbd_ready), 8'h00);

    // Tie right after reset goes to PS/2, then UART.
    push(0, 8'h41, 1'b1);
    push(1, 8'h42, 1'b1);
    next();
    wait_ready("tie_first");
    check("tie_first", ifc.kbd_data, 8'hC2);
    read_key();
    wait_ready("tie_second");
    check("tie_second", ifc.kbd_data, 8'hC1);

    // Reset during HOLD with a byte pending.
    push(0, 8'h33, 1'b1);
    next();
    do_reset();
    check("hold_rst_ready", 8'(ifc.kbd_ready), 8'h00);
    check("hold_rst_data", ifc.kbd_data, 8'h80);
    rst = 1'b0;
    repeat (6) next();
    check("hold_rst_dropped", 8'(ifc.kbd_ready), 8'h00);

    // Overflow: B1 goes to the register, 32..35 fill the FIFO, 36 is dropped.
    for (int i = 0; i < 5; i++) begin
      push(0, 8'h31 + 8'(i), 1'b1);
      next();
    end
    check("ovf_before", 8'(ifc.ovf), 8'h00);
    push(0, 8'h36, 1'b0);
    next();
    check("ovf_set", 8'(ifc.ovf), 8'h01);
    push(0, 8'h37, 1'b0);
    ifc.clr_ovf = 1'b1;
    next();
    check("ovf_set_beats_clr", 8'(ifc.ovf), 8'h01);
    ifc.clr_ovf = 1'b1;
    next();
    check("ovf_clr", 8'(ifc.ovf), 8'h00);
    // Push into the full FIFO on the edge its head is popped.
    read_key();
    repeat (HOLDOFF) next();
    push(0, 8'h39, 1'b1);
    next();
    check("full_push_pop", 8'(ifc.ovf), 8'h00);
    for (int i = 0; i < 5; i++) begin
      wait_ready("drain_ovf");
      read_key();
    end
    repeat (6) next();

    // Disabled source is ignored without overflow.
    ifc.src_en = 2'b10;
    push(0, 8'h41, 1'b1);
    repeat (6) next();
    check("dis_no_ready", 8'(ifc.kbd_ready), 8'h00);
    check("dis_no_ovf", 8'(ifc.ovf), 8'h00);

    // Disabling PS/2 flushes its queued bytes.
    ifc.src_en = 2'b11;
    push(0, 8'h41, 1'b1);
    next();
    wait_ready("flush_hold");
    push(1, 8'h62, 1'b1);
    next();
    push(1, 8'h63, 1'b1);
    next();
    ifc.src_en = 2'b01;
    pq.delete();
    next();
    next();
    ifc.src_en = 2'b11;
    read_key();
    repeat (8) next();
    check("flush_nothing", 8'(ifc.kbd_ready), 8'h00);

    // Lowercase byte.
    push(1, 8'h61, 1'b1);
    next();
    wait_ready("fold");
`ifdef KBD_UPPERCASE_FOLD_EN
    check("fold", ifc.kbd_data, 8'hC1);
`else
    check("fold", ifc.kbd_data, 8'hE1);
`endif
    read_key();

    // Random traffic; queue occupancy is kept below depth so nothing drops.
    for (int s = 0; s < 600; s++) begin
      if (uq.size() < FIFO_DEPTH && $urandom_range(0, 3) == 0) begin
        r = 8'($urandom);
        push(0, r, 1'b1);
      end
      if (pq.size() < FIFO_DEPTH && $urandom_range(0, 3) == 0) begin
        r = 8'($urandom);
        push(1, r, 1'b1);
      end
      if (ifc.kbd_ready && $urandom_range(0, 2) == 0) ifc.kbd_rd = 1'b1;
      if ($urandom_range(0, 15) == 0) ifc.clr_ovf = 1'b1;
      next();
    end
    n = 0;
    while ((uq.size() > 0 || pq.size() > 0) && n < 500) begin
      if (ifc.kbd_ready) ifc.kbd_rd = 1'b1;
      next();
      n++;
    end
    n_checks++;
    if (uq.size() != 0 || pq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d UART and %0d PS/2 keys never presented", uq.size(), pq.size());
    end
    check("final_ovf", 8'(ifc.ovf), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
